// File: rtl/align_stage_pkg.sv
// Shared definitions for the vfpu pre-add alignment stage.
// Default widths match the norm/round stages of the add path.
package align_stage_pkg;

  localparam int FRAC_W_DEF = 24;
  localparam int EXP_W_DEF  = 10;
  localparam int GRS_W_DEF  = 3;

  typedef enum logic {
    BIG_A = 1'b0,
    BIG_B = 1'b1
  } big_sel_e;

endpackage

// File: rtl/align_shifter.sv
// Right shifter for the smaller mantissa: appends the GRS field, shifts by the
// exponent difference and folds every bit shifted out into the output LSB.
module align_shifter #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 27,
  parameter int SH_W  = 10
) (
  input  logic [IN_W-1:0]  frac_i,
  input  logic [SH_W-1:0]  shift_i,
  output logic [OUT_W-1:0] frac_o
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] shifted;
  logic [OUT_W-1:0] lost_mask;
  logic             sticky;

  always_comb begin
    ext       = {frac_i, {PAD_W{1'b0}}};
    shifted   = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    // A shift of the full width or more loses everything; only the sticky survives.
    if (32'(shift_i) >= OUT_W) begin
      sticky = |ext;
    end else begin
      shifted   = ext >> shift_i;
      lost_mask = ~({OUT_W{1'b1}} << shift_i);
      sticky    = |(ext & lost_mask);
    end
    frac_o = shifted | {{(OUT_W-1){1'b0}}, sticky};
  end

endmodule

// File: rtl/align_stage.sv
// Pre-add alignment: picks the larger-magnitude operand and right-aligns the
// smaller mantissa with sticky collection. Two registered stages, valid/ready.
module align_stage
  import align_stage_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int EXP_W  = EXP_W_DEF,
  parameter int GRS_W  = GRS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    s_a,
  input  logic                    s_b,
  input  logic [EXP_W-1:0]        exp_a,
  input  logic [EXP_W-1:0]        exp_b,
  input  logic [FRAC_W-1:0]       frac_a,
  input  logic [FRAC_W-1:0]       frac_b,
  input  logic                    sub_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    s_tmp,
  output logic                    eff_sub,
  output logic [EXP_W-1:0]        exp_tmp,
  output logic [FRAC_W+GRS_W-1:0] frac_big,
  output logic [FRAC_W+GRS_W-1:0] frac_small
);

  localparam int OUT_W = FRAC_W + GRS_W;

  typedef struct packed {
    logic              s_tmp;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp;
    logic [EXP_W-1:0]  diff;
    logic [FRAC_W-1:0] frac_big;
    logic [FRAC_W-1:0] frac_small;
  } s1_t;

  typedef struct packed {
    logic              s_tmp;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp;
    logic [OUT_W-1:0]  frac_big;
    logic [OUT_W-1:0]  frac_small;
  } s2_t;

  big_sel_e         big_sel;
  s1_t              s1_new;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic             s1_vld_d, s1_vld_q;
  logic             s2_vld_d, s2_vld_q;
  logic             s2_free;
  logic             accept;
  logic             s2_load;
  logic [EXP_W-1:0] exp_small;
  logic [OUT_W-1:0] frac_small_sh;

  // Compare/swap ahead of S1: equal magnitude keeps a as the big operand.
  always_comb begin
    big_sel   = ({exp_a, frac_a} >= {exp_b, frac_b}) ? BIG_A : BIG_B;
    s1_new    = '0;
    exp_small = '0;
    s1_new.eff_sub = s_a ^ s_b ^ sub_op;
    if (big_sel == BIG_A) begin
      s1_new.s_tmp      = s_a;
      s1_new.exp        = exp_a;
      s1_new.frac_big   = frac_a;
      s1_new.frac_small = frac_b;
      exp_small         = exp_b;
    end else begin
      s1_new.s_tmp      = s_b ^ sub_op;
      s1_new.exp        = exp_b;
      s1_new.frac_big   = frac_b;
      s1_new.frac_small = frac_a;
      exp_small         = exp_a;
    end
    s1_new.diff = s1_new.exp - exp_small;
  end

  // Handshake: S2 frees up when empty or draining; S1 follows S2.
  assign s2_free  = ~s2_vld_q | out_ready;
  assign in_ready = ~s1_vld_q | s2_free;
  assign accept   = in_valid & in_ready;
  assign s2_load  = s1_vld_q & s2_free;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    if (in_ready) s1_vld_d = in_valid;
    if (s2_free)  s2_vld_d = s1_vld_q;
    if (flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end
  end

  align_shifter #(
    .IN_W  (FRAC_W),
    .OUT_W (OUT_W),
    .SH_W  (EXP_W)
  ) u_shifter (
    .frac_i  (s1_q.frac_small),
    .shift_i (s1_q.diff),
    .frac_o  (frac_small_sh)
  );

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    if (accept) s1_d = s1_new;
    if (s2_load) begin
      s2_d.s_tmp      = s1_q.s_tmp;
      s2_d.eff_sub    = s1_q.eff_sub;
      s2_d.exp        = s1_q.exp;
      s2_d.frac_big   = {s1_q.frac_big, {GRS_W{1'b0}}};
      s2_d.frac_small = frac_small_sh;
    end
  end

  // S1 -> S2 pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  assign out_valid  = s2_vld_q;
  assign s_tmp      = s2_q.s_tmp;
  assign eff_sub    = s2_q.eff_sub;
  assign exp_tmp    = s2_q.exp;
  assign frac_big   = s2_q.frac_big;
  assign frac_small = s2_q.frac_small;

endmodule

// File: tb/tb_align_stage.sv
// Scoreboard bench for align_stage: expected results are queued on accept
// and compared in order as the DUT hands them downstream.
`timescale 1ns/1ps
module tb_align_stage;

  localparam int FW = 24;
  localparam int EW = 10;
  localparam int GW = 3;
  localparam int OW = FW + GW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          s_a = 1'b0, s_b = 1'b0, sub_op = 1'b0;
  logic [EW-1:0] exp_a = '0, exp_b = '0;
  logic [FW-1:0] frac_a = '0, frac_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          s_tmp, eff_sub;
  logic [EW-1:0] exp_tmp;
  logic [OW-1:0] frac_big, frac_small;

  typedef struct packed {
    logic          s;
    logic          e;
    logic [EW-1:0] x;
    logic [OW-1:0] b;
    logic [OW-1:0] sm;
  } res_t;

  res_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   acc = 0;

  always #5 clk = ~clk;

  align_stage #(.FRAC_W(FW), .EXP_W(EW), .GRS_W(GW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .s_a(s_a), .s_b(s_b), .exp_a(exp_a), .exp_b(exp_b), .frac_a(frac_a), .frac_b(frac_b),
    .sub_op(sub_op), .out_valid(out_valid), .out_ready(out_ready), .s_tmp(s_tmp),
    .eff_sub(eff_sub), .exp_tmp(exp_tmp), .frac_big(frac_big), .frac_small(frac_small)
  );

  function automatic res_t model(input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                                 input logic sbit, input logic [EW-1:0] eb, input logic [FW-1:0] fb,
                                 input logic sub);
    res_t          r;
    logic [FW-1:0] fs;
    logic [OW-1:0] ext;
    int            d;
    logic          stk;
    r = '0;
    r.e = sa ^ sbit ^ sub;
    if (ea > eb || (ea == eb && fa >= fb)) begin
      r.s = sa; r.x = ea; r.b = {fa, 3'b000}; fs = fb; d = int'(ea) - int'(eb);
    end else begin
      r.s = sbit ^ sub; r.x = eb; r.b = {fb, 3'b000}; fs = fa; d = int'(eb) - int'(ea);
    end
    ext = {fs, 3'b000};
    stk = 1'b0;
    for (int i = 0; i < OW; i++) begin
      if (i < d) stk = stk | ext[i];
      else r.sm[i-d] = ext[i];
    end
    r.sm[0] = r.sm[0] | stk;
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    res_t a, e;
    if (mon_en && out_valid && out_ready) begin
      a = {s_tmp, eff_sub, exp_tmp, frac_big, frac_small};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got %h, required no output", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL out_data: got s=%b e=%b x=%0d b=%h sm=%h, required s=%b e=%b x=%0d b=%h sm=%h",
                   a.s, a.e, a.x, a.b, a.sm, e.s, e.e, e.x, e.b, e.sm);
        end
      end
    end
  end

  task automatic send(input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                      input logic sbit, input logic [EW-1:0] eb, input logic [FW-1:0] fb,
                      input logic sub, output int waited);
    s_a = sa; exp_a = ea; frac_a = fa; s_b = sbit; exp_b = eb; frac_b = fb; sub_op = sub;
    in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: in_ready=%b, required 1 within 100 cycles", in_ready);
        break;
      end
    end
    if (waited <= 100) sb.push_back(model(sa, ea, fa, sbit, eb, fb, sub));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int waited);
    logic [EW-1:0] ea, eb;
    ea = EW'($urandom_range(100, 160));
    eb = EW'($urandom_range(100, 160));
    send(1'($urandom), ea, {1'b1, 23'($urandom)}, 1'($urandom), eb, {1'b1, 23'($urandom)},
         1'($urandom), waited);
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: out_valid=%b, required 0", out_valid);
    end
    n_cmp++;
    if ({s_tmp, eff_sub, exp_tmp, frac_big, frac_small} !== '0) begin
      n_err++; $display("FAIL reset_data: exp=%0d b=%h sm=%h, required all 0", exp_tmp, frac_big, frac_small);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_no_output: out_valid=%b, required 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int w;
    out_ready = 1'b1;
    mon_en = 1'b1;
    send(1'b0, 10'd130, 24'hC00000, 1'b0, 10'd127, 24'h800000, 1'b0, w);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || exp_tmp !== 10'd130 || frac_big !== 27'h6000000 ||
        frac_small !== 27'h0800000 || eff_sub !== 1'b0) begin
      n_err++;
      $display("FAIL diff3: v=%b x=%0d b=%h sm=%h e=%b, required v=1 x=130 b=6000000 sm=0800000 e=0",
               out_valid, exp_tmp, frac_big, frac_small, eff_sub);
    end
    @(posedge clk); #1;
    send(1'b0, 10'd127, 24'h800000, 1'b1, 10'd128, 24'h800000, 1'b0, w);
    send(1'b0, 10'd170, 24'h900000, 1'b0, 10'd130, 24'h800001, 1'b0, w);
    send(1'b1, 10'd134, 24'hA00000, 1'b0, 10'd130, 24'h80000F, 1'b1, w);
    send(1'b1, 10'd120, 24'hABCDEF, 1'b0, 10'd120, 24'hABCDEF, 1'b1, w);
    send(1'b0, 10'd0,   24'h000000, 1'b1, 10'd0,   24'h000000, 1'b0, w);
    send(1'b0, 10'd140, 24'hFFFFFF, 1'b1, 10'd113, 24'hFFFFFF, 1'b1, w);
    send(1'b1, 10'd150, 24'h800000, 1'b0, 10'd150, 24'h800001, 1'b0, w);
    drain();
  endtask

  task automatic test_back_to_back();
    int w, total;
    total = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_rand(w);
      total += w;
    end
    n_cmp++;
    if (total !== 0) begin
      n_err++; $display("FAIL throughput: %0d stall cycles with out_ready=1, required 0", total);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [2*OW+EW+1:0] snap;
    out_ready = 1'b0;
    acc = 0;
    fork
      begin
        int w;
        for (int i = 0; i < 5; i++) begin
          send_rand(w);
          acc++;
        end
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || acc !== 2) begin
          n_err++; $display("FAIL bp_in_ready: in_ready=%b accepts=%0d, required 0 and 2", in_ready, acc);
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_err++; $display("FAIL bp_valid: out_valid=%b, required 1", out_valid);
        end
        snap = {s_tmp, eff_sub, exp_tmp, frac_big, frac_small};
        repeat (3) begin
          @(negedge clk);
          n_cmp++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
              {s_tmp, eff_sub, exp_tmp, frac_big, frac_small} !== snap) begin
            n_err++;
            $display("FAIL bp_hold: v=%b rdy=%b data=%h, required v=1 rdy=0 data=%h", out_valid, in_ready,
                     {s_tmp, eff_sub, exp_tmp, frac_big, frac_small}, snap);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_flush();
    int w;
    out_ready = 1'b0;
    send_rand(w);
    send_rand(w);
    mon_en = 1'b0;
    s_a = 1'b0; exp_a = 10'd140; frac_a = 24'h900000;
    s_b = 1'b0; exp_b = 10'd139; frac_b = 24'h800000; sub_op = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_setup: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_kill: out_valid=%b %0d cycles after flush, required 0", out_valid, i);
      end
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    send(1'b1, 10'd90, 24'hC0FFEE, 1'b0, 10'd95, 24'h812345, 1'b1, w);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_new_early: out_valid=%b, required 0", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL flush_new_latency: out_valid=%b 2 cycles after accept, required 1", out_valid);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 1'b1;
    mon_en = 1'b1;
    send_rand(w);
    send_rand(w);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_mid_pulse: out_valid=%b after reset, required 0", out_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
